// File: rtl/insai_dummy_fu_pkg.sv
// -----------------------------------------------------------------------------
// insai_dummy_fu_pkg
//   Shared types for the insAI dummy functional unit: a trimmed core
//   configuration record, the issue-stage operand bundle (fu_data_t) and the
//   writeback exception record (exception_t).
// -----------------------------------------------------------------------------
package insai_dummy_fu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    // Only the datapath width is consumed by the unit.
    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32};

    typedef struct packed {
        logic [7:0]               operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [XLEN-1:0]          imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

endpackage

// File: rtl/insai_dummy_fu.sv
// -----------------------------------------------------------------------------
// insai_dummy_fu
//   Multi-cycle byte-lane dot product unit. Accepts one request from the issue
//   stage, walks one byte lane per cycle (signed or unsigned 8x8 multiply,
//   accumulated modulo 2^XLEN) and returns the sum with the request's trans_id
//   as a single-cycle writeback pulse.
//
//   Build option: define INSAI_FU_ACCUM_EN to seed the accumulator with the
//   request's imm (result = imm + sum of products). Without it the accumulator
//   starts at zero and imm is ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                kill in-flight op / pending result
//   fu_data_i              operands, imm, trans_id, operation[0]=unsigned
//   dummy_FU_valid_i/_ready_o   issue handshake
//   dummy_FU_trans_id_o, _result_o, _valid_o   writeback (no backpressure)
//   dummy_FU_exception_o   never raised
// -----------------------------------------------------------------------------
module insai_dummy_fu
    import insai_dummy_fu_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
    parameter int unsigned NR_LANES = CVA6Cfg.XLEN / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  fu_data_t                      fu_data_i,
    input  logic                          dummy_FU_valid_i,
    output logic                          dummy_FU_ready_o,
    output logic [TRANS_ID_BITS-1:0]      dummy_FU_trans_id_o,
    output logic [CVA6Cfg.XLEN-1:0]       dummy_FU_result_o,
    output logic                          dummy_FU_valid_o,
    output exception_t                    dummy_FU_exception_o
);

    localparam int unsigned W     = CVA6Cfg.XLEN;
    localparam int unsigned CNT_W = (NR_LANES > 1) ? $clog2(NR_LANES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                   state_q, state_d;
    logic [W-1:0]             a_q, b_q;
    logic [W-1:0]             acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [TRANS_ID_BITS-1:0] tid_q;
    logic                     uns_q;
    logic                     accept;

    // Operands shift right one byte per BUSY cycle, so the active lane is
    // always bits [7:0]; no variable-index mux is needed.
    logic signed [15:0] sa, sb, sprod;
    logic        [15:0] ua, ub, uprod;
    logic [W-1:0]       lane_ext;

    always_comb begin
        sa       = {{8{a_q[7]}}, a_q[7:0]};
        sb       = {{8{b_q[7]}}, b_q[7:0]};
        ua       = {8'h00, a_q[7:0]};
        ub       = {8'h00, b_q[7:0]};
        // Full 8x8 products fit in 16 bits in both modes.
        sprod    = sa * sb;
        uprod    = ua * ub;
        lane_ext = uns_q ? {{(W-16){1'b0}}, uprod}
                         : {{(W-16){sprod[15]}}, sprod};
    end

    // Next state and handshake outputs; flush overrides everything.
    always_comb begin
        state_d          = state_q;
        dummy_FU_ready_o = 1'b0;
        dummy_FU_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                dummy_FU_ready_o = ~flush_i;
                if (dummy_FU_valid_i && !flush_i) state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == CNT_W'(NR_LANES - 1)) state_d = DONE;
            end
            DONE: begin
                dummy_FU_valid_o = ~flush_i;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    assign accept = dummy_FU_valid_i & dummy_FU_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tid_q   <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= fu_data_i.operand_a;
                b_q   <= fu_data_i.operand_b;
                tid_q <= fu_data_i.trans_id;
                uns_q <= fu_data_i.operation[0];
                cnt_q <= '0;
`ifdef INSAI_FU_ACCUM_EN
                acc_q <= fu_data_i.imm;
`else
                acc_q <= '0;
`endif
            end else if (state_q == BUSY && !flush_i) begin
                acc_q <= acc_q + lane_ext;
                cnt_q <= cnt_q + CNT_W'(1);
                a_q   <= a_q >> 8;
                b_q   <= b_q >> 8;
            end
        end
    end

    // Result and tag are straight register outputs.
    assign dummy_FU_result_o    = acc_q;
    assign dummy_FU_trans_id_o  = tid_q;
    assign dummy_FU_exception_o = '0;

    // Fields of the operand bundle this unit does not consume.
    logic unused_fu_bits;
`ifdef INSAI_FU_ACCUM_EN
    assign unused_fu_bits = ^fu_data_i.operation[7:1];
`else
    assign unused_fu_bits = ^{fu_data_i.operation[7:1], fu_data_i.imm};
`endif

endmodule

// File: tb/tb_insai_dummy_fu.sv
module tb_insai_dummy_fu;
    import insai_dummy_fu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    fu_data_t    fu_data = '0;
    logic        vld_i = 1'b0;
    logic        ready;
    logic [2:0]  tid_o;
    logic [31:0] result;
    logic        vld_o;
    exception_t  exc;

    int errors = 0;
    int checks = 0;

    insai_dummy_fu dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .fu_data_i           (fu_data),
        .dummy_FU_valid_i    (vld_i),
        .dummy_FU_ready_o    (ready),
        .dummy_FU_trans_id_o (tid_o),
        .dummy_FU_result_o   (result),
        .dummy_FU_valid_o    (vld_o),
        .dummy_FU_exception_o(exc)
    );

    always #5 clk = ~clk;

    // Reference: sum of per-byte products, seeded by imm in the accumulate build.
    function automatic logic [31:0] ref_dot(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] imm, input bit uns);
        longint s;
        int     x, y;
        logic [7:0] ab, bb;
        s = 0;
`ifdef INSAI_FU_ACCUM_EN
        s = longint'(imm);
`endif
        for (int i = 0; i < 4; i++) begin
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            if (uns) begin
                x = int'(ab);
                y = int'(bb);
            end else begin
                x = int'($signed(ab));
                y = int'($signed(bb));
            end
            s += longint'(x * y);
        end
        return s[31:0];
    endfunction

    // Present a request and return just after the accepting clock edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [2:0] tid, input bit uns, input bit hold, output bit ok);
        @(negedge clk);
        fu_data.operand_a = a;
        fu_data.operand_b = b;
        fu_data.imm       = imm;
        fu_data.trans_id  = tid;
        fu_data.operation = {7'h0, uns};
        vld_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!hold) vld_i = 1'b0;
    endtask

    // Count cycles after the accept edge until the writeback pulse.
    task automatic wait_wb(output int lat, output logic [31:0] res, output logic [2:0] tid,
                           output int rdy_hi);
        lat = -1;
        res = 'x;
        tid = 'x;
        rdy_hi = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            #1;
            if (vld_o) begin
                lat = n;
                res = result;
                tid = tid_o;
                break;
            end
            if (ready) rdy_hi++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vld_o); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (tid_o !== 3'd0) begin errors++; $display("FAIL reset_tid got=%0d exp=0", tid_o); end
        checks++; if (exc !== '0) begin errors++; $display("FAIL reset_exc got=%h exp=0", exc); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        bit ok; int lat, rh; logic [31:0] r; logic [2:0] t; logic [31:0] exp_r;
`ifdef INSAI_FU_ACCUM_EN
        exp_r = 32'h0000006E;
`else
        exp_r = 32'h0000000A;
`endif
        send(32'h01020304, 32'h01010101, 32'd100, 3'd3, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept got=0 exp=1"); end
        wait_wb(lat, r, t, rh);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (r !== exp_r) begin errors++; $display("FAIL basic_result got=%h exp=%h", r, exp_r); end
        checks++; if (t !== 3'd3) begin errors++; $display("FAIL basic_tid got=%0d exp=3", t); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL basic_ready_busy got=%0d exp=0", rh); end
        checks++; if (exc !== '0) begin errors++; $display("FAIL basic_exc got=%h exp=0", exc); end
        @(negedge clk); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", vld_o); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", ready); end
    endtask

    task automatic test_sign;
        bit ok; int lat, rh; logic [31:0] r; logic [2:0] t;
        send(32'hFFFFFFFF, 32'h01010101, 32'd0, 3'd1, 1'b0, 1'b0, ok);
        wait_wb(lat, r, t, rh);
        checks++; if (r !== 32'hFFFFFFFC) begin errors++; $display("FAIL signed_result got=%h exp=fffffffc", r); end
        send(32'hFFFFFFFF, 32'h01010101, 32'd0, 3'd2, 1'b1, 1'b0, ok);
        wait_wb(lat, r, t, rh);
        checks++; if (r !== 32'h000003FC) begin errors++; $display("FAIL unsigned_result got=%h exp=000003fc", r); end
        checks++; if (t !== 3'd2) begin errors++; $display("FAIL unsigned_tid got=%0d exp=2", t); end
    endtask

    task automatic test_busy_reject;
        bit ok; int lat, rh; logic [31:0] r; logic [2:0] t; logic [31:0] exp2;
        send(32'h01020304, 32'h01010101, 32'd0, 3'd3, 1'b0, 1'b1, ok);
        fu_data.operand_a = 32'h10203040;
        fu_data.operand_b = 32'h02020202;
        fu_data.trans_id  = 3'd5;
        exp2 = ref_dot(32'h10203040, 32'h02020202, 32'd0, 1'b0);
        wait_wb(lat, r, t, rh);
        checks++; if (t !== 3'd3) begin errors++; $display("FAIL reject_first_tid got=%0d exp=3", t); end
        checks++; if (r !== 32'h0000000A) begin errors++; $display("FAIL reject_first_result got=%h exp=0000000a", r); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL reject_ready_busy got=%0d exp=0", rh); end
        @(negedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reject_ready_rise got=%b exp=1", ready); end
        @(posedge clk); #1;
        vld_i = 1'b0;
        wait_wb(lat, r, t, rh);
        checks++; if (lat !== 5) begin errors++; $display("FAIL reject_second_latency got=%0d exp=5", lat); end
        checks++; if (t !== 3'd5) begin errors++; $display("FAIL reject_second_tid got=%0d exp=5", t); end
        checks++; if (r !== exp2) begin errors++; $display("FAIL reject_second_result got=%h exp=%h", r, exp2); end
    endtask

    task automatic test_flush;
        bit ok; int seen;
        // flush while the third lane is being processed
        send(32'h01020304, 32'h01010101, 32'd0, 3'd4, 1'b0, 1'b0, ok);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_busy_ready got=%b exp=0", ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_busy_ready_next got=%b exp=1", ready); end
        seen = 0;
        repeat (10) begin @(negedge clk); #1; if (vld_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_busy_wb got=%0d exp=0", seen); end
        // flush in the writeback cycle
        send(32'h01020304, 32'h01010101, 32'd0, 3'd6, 1'b0, 1'b0, ok);
        repeat (4) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL flush_done_valid got=%b exp=0", vld_o); end
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); #1; if (vld_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_done_wb got=%0d exp=0", seen); end
        // flush in idle with a request presented
        @(negedge clk);
        fu_data.trans_id = 3'd7;
        vld_i = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got=%b exp=0", ready); end
        @(posedge clk); #1;
        vld_i = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); #1; if (vld_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_idle_accept got=%0d exp=0", seen); end
    endtask

    task automatic test_random;
        bit ok; int lat, rh; logic [31:0] r; logic [2:0] t;
        logic [31:0] a, b, imm, exp_r; logic [2:0] tid; bit uns;
        for (int k = 0; k < 16; k++) begin
            a = $urandom; b = $urandom; imm = $urandom;
            tid = 3'($urandom_range(0, 7));
            uns = 1'($urandom_range(0, 1));
            if (k == 0) begin a = 32'h80808080; b = 32'h80808080; end
            if (k == 1) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; uns = 1'b1; end
            exp_r = ref_dot(a, b, imm, uns);
            send(a, b, imm, tid, uns, 1'b0, ok);
            wait_wb(lat, r, t, rh);
            checks++;
            if (lat !== 5 || r !== exp_r || t !== tid) begin
                errors++;
                $display("FAIL random_op%0d got lat=%0d res=%h tid=%0d exp lat=5 res=%h tid=%0d",
                         k, lat, r, t, exp_r, tid);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int seen;
        send(32'h01020304, 32'h01010101, 32'd9, 3'd6, 1'b0, 1'b0, ok);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (result !== 32'h0 || tid_o !== 3'd0 || vld_o !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got res=%h tid=%0d vld=%b exp 0", result, tid_o, vld_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge clk); #1; if (vld_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_wb got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_busy_reject();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/insai_dummy_fu.md
# insai_dummy_fu

Multi-cycle custom functional unit for the insAI extension. It sits in the execute stage as the consumer of the issue stage's `dummy_FU_valid`/`dummy_FU_ready` handshake and drives one scoreboard writeback port. It computes a packed byte-lane dot product of `operand_a` and `operand_b`, processing one lane per cycle. The result is returned with the instruction's `trans_id`.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; only `riscv::XLEN` matters here.
- `NR_LANES`, default `riscv::XLEN/8`: number of byte lanes processed; equals the cycle count of the BUSY phase.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  kill the in-flight operation and any pending result.
- `fu_data_i`  in  `fu_data_t`  operands, `imm`, `trans_id`, `operation`.
- `dummy_FU_valid_i`  in  1  issue request.
- `dummy_FU_ready_o`  out  1  unit can accept a request this cycle.
- `dummy_FU_trans_id_o`  out  `TRANS_ID_BITS`  scoreboard tag of the result.
- `dummy_FU_result_o`  out  XLEN  result data.
- `dummy_FU_valid_o`  out  1  writeback valid, a one-cycle pulse.
- `dummy_FU_exception_o`  out  `exception_t`  always `valid=0`, all other fields 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `dummy_FU_ready_o = ~flush_i`.
  - Accept when `dummy_FU_valid_i & dummy_FU_ready_o`.
  - On accept, latch `operand_a`, `operand_b`, `imm`, `trans_id` and `operation[0]` (0 = signed, 1 = unsigned).
  - On accept, clear the accumulator and the lane counter, then go to BUSY.
- BUSY:
  - Each cycle, lane `i` (bits `8i+7:8i`) of a and b is multiplied and the product added to the accumulator.
  - Signed mode: 8×8 signed product, sign-extended to XLEN. Unsigned mode: zero-extended.
  - The accumulator wraps modulo 2^XLEN.
  - The counter increments. When lane `NR_LANES-1` is processed, go to DONE.
- DONE:
  - `dummy_FU_valid_o = ~flush_i`.
  - The result and `trans_id_o` are held from the latches.
  - Next state is IDLE unconditionally.
- `dummy_FU_ready_o` is 0 in BUSY and DONE. A valid in those states is ignored and not latched.
- The writeback port has no backpressure. The result is presented for exactly one cycle.
- `flush_i` from any state:
  - Next state is IDLE.
  - In the same cycle, `dummy_FU_valid_o` and `dummy_FU_ready_o` are forced to 0.
  - Latched operands are discarded.
- Reset:
  - State = IDLE, accumulator = 0, counter = 0, latched `trans_id` = 0.
  - All outputs are 0, except `dummy_FU_ready_o`, which is 1 (IDLE with no flush).
  - Reset asserted mid-operation drops the operation with no writeback.

## Timing
- Accept at clock edge k (cycle k has valid & ready).
- BUSY occupies cycles k+1 … k+NR_LANES.
- DONE occupies cycle k+NR_LANES+1, with `dummy_FU_valid_o` high.
- Latency from the accept cycle to the writeback cycle is NR_LANES+1 cycles.
- `dummy_FU_ready_o` is high again in cycle k+NR_LANES+2. Maximum throughput is one operation per NR_LANES+2 cycles.
- `dummy_FU_result_o` and `dummy_FU_trans_id_o` come directly from registers, with no combinational path from the inputs. They are stable throughout DONE.
- The only combinational input→output paths are `flush_i` → `ready_o` and `flush_i` → `valid_o`.

## Configuration
- Macro: `INSAI_FU_ACCUM_EN`.
- Defined: on accept, the accumulator is initialised to the latched `imm` instead of 0, giving result = imm + Σ products (modulo 2^XLEN).
- Undefined: `imm` is not latched, the accumulator starts at 0, and result = Σ products. No `imm` register is synthesised.
- Timing and handshake behaviour are identical in both builds.

## Test plan
- Basic signed dot product, XLEN=32, signed:
  - Stimulus: a=0x01020304, b=0x01010101, trans_id=3.
  - Required: `valid_o` high exactly 5 cycles after the accept cycle, result=0x0000000A, trans_id_o=3, `ready_o` low for 5 cycles.
- Signed versus unsigned, a=0xFFFFFFFF, b=0x01010101:
  - Signed: result=0xFFFFFFFC.
  - Unsigned (`operation[0]=1`): result=0x000003FC.
- Busy rejection:
  - Stimulus: a second valid with trans_id=5 is held through BUSY and DONE.
  - Required: not accepted until `ready_o` rises; the first result keeps trans_id 3; the second operation completes afterwards with trans_id 5.
- Flush handling:
  - Flush in BUSY (lane 2): no writeback pulse ever; `ready_o` high the next cycle.
  - Flush in the DONE cycle: `valid_o` stays 0.
  - Flush while valid is presented in IDLE: no accept.
- Accumulate build, `INSAI_FU_ACCUM_EN` defined:
  - Stimulus: a=0x01020304, b=0x01010101, imm=100.
  - Required: result=0x0000006E (110).
  - Same stimulus with the macro undefined: result=0x0000000A.
- Reset mid-operation:
  - Stimulus: `rst_ni` asserted during BUSY.
  - Required: all outputs return to their reset values (`ready_o`=1) asynchronously; no writeback is issued after release.
